accelerator_standard_fnn_sequencer: RTL and testbench

Sequencer for one fully-connected layer of the standard FNN controller: h[l] = b[l] + Σx W[l][x]·x[x] for l in 0..SIZE_L-1, x in 0..SIZE_X-1. It requests operands element by element from the weight/input stores and accumulates them in an internal MAC. It emits one result per output neuron to the downstream activation stage under a valid/ready handshake. It sits between the NTM controller's operand memories and the activation unit.

---
 rtl/accelerator_standard_fnn_sequencer_pkg.sv | 17 +
 rtl/accelerator_standard_fnn_sequencer_if.sv | 34 +++
 rtl/accelerator_standard_fnn_sequencer_mac.sv | 21 ++
 rtl/accelerator_standard_fnn_sequencer.sv | 105 ++++++++++
 tb/tb_accelerator_standard_fnn_sequencer.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/accelerator_standard_fnn_sequencer_pkg.sv
// Shared widths, FSM state encoding and reset constants for the FNN layer sequencer.
// No logic, so no latency and no backpressure.
package accelerator_standard_fnn_pkg;

    localparam int DATA_SIZE    = 64;
    localparam int CONTROL_SIZE = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EMIT  = 2'd2
    } state_t;

    localparam logic [DATA_SIZE-1:0]    ZERO_DATA = '0;
    localparam logic [CONTROL_SIZE-1:0] ZERO_CTRL = '0;

endpackage

// File: rtl/accelerator_standard_fnn_sequencer_if.sv
// Start/size, operand-fetch and result handshake bundle; master is the sequencer side.
// Wires only, so no latency; backpressure is carried by operand_valid and h_out_ready.
interface accelerator_standard_fnn_sequencer_if;
    import accelerator_standard_fnn_pkg::*;

    logic                    start;
    logic                    ready;
    logic [CONTROL_SIZE-1:0] size_x_in;
    logic [CONTROL_SIZE-1:0] size_l_in;
    logic                    operand_req;
    logic [CONTROL_SIZE-1:0] operand_l_index;
    logic [CONTROL_SIZE-1:0] operand_x_index;
    logic                    operand_valid;
    logic [DATA_SIZE-1:0]    w_in;
    logic [DATA_SIZE-1:0]    x_in;
    logic [DATA_SIZE-1:0]    b_in;
    logic [DATA_SIZE-1:0]    h_out;
    logic [CONTROL_SIZE-1:0] h_out_l_index;
    logic                    h_out_enable;
    logic                    h_out_ready;

    modport master (
        input  start, size_x_in, size_l_in, operand_valid, w_in, x_in, b_in, h_out_ready,
        output ready, operand_req, operand_l_index, operand_x_index,
               h_out, h_out_l_index, h_out_enable
    );

    modport slave (
        output start, size_x_in, size_l_in, operand_valid, w_in, x_in, b_in, h_out_ready,
        input  ready, operand_req, operand_l_index, operand_x_index,
               h_out, h_out_l_index, h_out_enable
    );

endinterface

// File: rtl/accelerator_standard_fnn_sequencer_mac.sv
// Combinational multiply-add: result = lo(w*x) + (load_bias ? bias : acc), wrapping.
// Zero latency, no handshake; the sequencer decides when the result is registered.
module accelerator_standard_fnn_mac
    import accelerator_standard_fnn_pkg::*;
(
    input  logic [DATA_SIZE-1:0] w,
    input  logic [DATA_SIZE-1:0] x,
    input  logic [DATA_SIZE-1:0] bias,
    input  logic [DATA_SIZE-1:0] acc,
    input  logic                 load_bias,
    output logic [DATA_SIZE-1:0] result
);

    // Only the low DATA_SIZE bits of the product are kept; those are identical for
    // signed and unsigned operands, so the signed cast documents intent only.
    logic signed [DATA_SIZE-1:0] prod;

    assign prod   = $signed(w) * $signed(x);
    assign result = DATA_SIZE'(prod) + (load_bias ? bias : acc);

endmodule

// File: rtl/accelerator_standard_fnn_sequencer.sv
// Layer sequencer: h[l] = b[l] + sum_x W[l][x]*x[x], one operand beat per cycle, SIZE_X+1 cycles per neuron.
// Operand stalls hold the indices; a result is held in EMIT until h_out_ready accepts it.
module accelerator_standard_fnn_sequencer
    import accelerator_standard_fnn_pkg::*;
(
    input  logic                                clk,
    input  logic                                rst_n,
    accelerator_standard_fnn_sequencer_if.master bus
);

    state_t                  state, state_nxt;
    logic [CONTROL_SIZE-1:0] size_x, size_l;
    logic [CONTROL_SIZE-1:0] l_idx, x_idx;
    logic [DATA_SIZE-1:0]    acc, h_dat, mac_dat;
    logic [CONTROL_SIZE-1:0] h_l_idx;
    logic                    start_ok, beat, last_x, last_l, h_acc;

    assign start_ok = bus.start && (bus.size_x_in != ZERO_CTRL) && (bus.size_l_in != ZERO_CTRL);
    assign beat     = (state == FETCH) && bus.operand_valid;
    assign last_x   = (x_idx == size_x - CONTROL_SIZE'(1));
    assign last_l   = (l_idx == size_l - CONTROL_SIZE'(1));
    assign h_acc    = (state == EMIT) && bus.h_out_ready;

    accelerator_standard_fnn_mac u_mac (
        .w         (bus.w_in),
        .x         (bus.x_in),
        .bias      (bus.b_in),
        .acc       (acc),
        .load_bias (x_idx == ZERO_CTRL),
        .result    (mac_dat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ok)      state_nxt = FETCH;
            FETCH:   if (beat && last_x) state_nxt = EMIT;
            EMIT:    if (h_acc)         state_nxt = last_l ? IDLE : FETCH;
            default:                    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            size_x  <= ZERO_CTRL;
            size_l  <= ZERO_CTRL;
            l_idx   <= ZERO_CTRL;
            x_idx   <= ZERO_CTRL;
            acc     <= ZERO_DATA;
            h_dat   <= ZERO_DATA;
            h_l_idx <= ZERO_CTRL;
        end else begin
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        size_x <= bus.size_x_in;
                        size_l <= bus.size_l_in;
                        l_idx  <= ZERO_CTRL;
                        x_idx  <= ZERO_CTRL;
                    end
                end
                FETCH: begin
                    if (beat) begin
                        acc <= mac_dat;
                        if (last_x) begin
                            h_dat   <= mac_dat;
                            h_l_idx <= l_idx;
                        end else begin
                            x_idx <= x_idx + CONTROL_SIZE'(1);
                        end
                    end
                end
                EMIT: begin
                    if (h_acc) begin
                        x_idx <= ZERO_CTRL;
                        if (last_l) begin
                            // Leave IDLE with every output back at its reset value.
                            l_idx   <= ZERO_CTRL;
                            acc     <= ZERO_DATA;
                            h_dat   <= ZERO_DATA;
                            h_l_idx <= ZERO_CTRL;
                        end else begin
                            l_idx <= l_idx + CONTROL_SIZE'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ready           = (state == IDLE);
    assign bus.operand_req     = (state == FETCH);
    assign bus.h_out_enable    = (state == EMIT);
    assign bus.operand_l_index = l_idx;
    assign bus.operand_x_index = x_idx;
    assign bus.h_out           = h_dat;
    assign bus.h_out_l_index   = h_l_idx;

endmodule

// File: tb/tb_accelerator_standard_fnn_sequencer.sv
// Directed bench for the FNN layer sequencer with an operand-store model and a result scoreboard.
module tb_accelerator_standard_fnn_sequencer;
    import accelerator_standard_fnn_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    accelerator_standard_fnn_sequencer_if bus();

    accelerator_standard_fnn_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [63:0] h;
        logic [63:0] l;
    } exp_t;

    int          tests = 0;
    int          fails = 0;
    exp_t        sb[$];
    logic [63:0] w_mem [4][4];
    logic [63:0] x_mem [4];
    logic [63:0] b_mem [4];
    bit          vpat[$];
    int          vptr;
    int          hold_left;
    int          cur_sx, cur_sl;
    bit          exp_en, exp_fetch, prev_stall, prev_wait;
    logic [63:0] exp_fetch_l, prev_l, prev_x, prev_h, prev_hl;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
        tests++;
        assert (got === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
        end
    endtask

    task automatic clear_flags();
        exp_en = 0; exp_fetch = 0; prev_stall = 0; prev_wait = 0;
    endtask

    // Sample DUT outputs after an edge, check them, then drive inputs for the next edge.
    task automatic eval();
        logic [63:0] li, xi;
        exp_t e;
        if (exp_en)    chk("enable_after_last_beat", 64'(bus.h_out_enable), 64'd1);
        if (exp_fetch) begin
            chk("fetch_after_accept", 64'(bus.operand_req), 64'd1);
            chk("fetch_l_index", bus.operand_l_index, exp_fetch_l);
        end
        if (prev_stall) begin
            chk("stall_l_held", bus.operand_l_index, prev_l);
            chk("stall_x_held", bus.operand_x_index, prev_x);
        end
        if (prev_wait) begin
            chk("hold_h_out", bus.h_out, prev_h);
            chk("hold_h_index", bus.h_out_l_index, prev_hl);
            chk("no_req_in_emit", 64'(bus.operand_req), 64'd0);
        end
        clear_flags();

        if (bus.operand_req) begin
            li = bus.operand_l_index;
            xi = bus.operand_x_index;
            bus.w_in = w_mem[li[1:0]][xi[1:0]];
            bus.x_in = x_mem[xi[1:0]];
            bus.b_in = b_mem[li[1:0]];
            bus.operand_valid = vpat[vptr];
            vptr = (vptr + 1) % vpat.size();
            if (!bus.operand_valid) begin
                prev_stall = 1; prev_l = li; prev_x = xi;
            end else if (xi == 64'(cur_sx - 1)) begin
                exp_en = 1;
            end
        end else begin
            bus.operand_valid = 1'b0;
        end

        if (bus.h_out_enable) begin
            if (hold_left > 0) begin
                bus.h_out_ready = 1'b0;
                hold_left--;
                prev_wait = 1; prev_h = bus.h_out; prev_hl = bus.h_out_l_index;
            end else begin
                bus.h_out_ready = 1'b1;
                if (sb.size() == 0) begin
                    chk("scoreboard_underflow", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("h_out", bus.h_out, e.h);
                    chk("h_out_l_index", bus.h_out_l_index, e.l);
                    if (e.l != 64'(cur_sl - 1)) begin
                        exp_fetch = 1; exp_fetch_l = e.l + 64'd1;
                    end
                end
            end
        end else begin
            bus.h_out_ready = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        eval();
    endtask

    task automatic push_model(input int sx, input int sl);
        exp_t e;
        logic [63:0] a;
        for (int l = 0; l < sl; l++) begin
            a = b_mem[l];
            for (int x = 0; x < sx; x++) a = a + w_mem[l][x] * x_mem[x];
            e.h = a; e.l = 64'(l);
            sb.push_back(e);
        end
    endtask

    task automatic start_pass(input int sx, input int sl);
        cur_sx = sx; cur_sl = sl; vptr = 0;
        push_model(sx, sl);
        bus.size_x_in = 64'(sx);
        bus.size_l_in = 64'(sl);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.size_x_in = 64'd9;
        bus.size_l_in = 64'd9;
        eval();
    endtask

    task automatic run_pass(input int sx, input int sl, input int exp_cycles);
        int n;
        start_pass(sx, sl);
        n = 0;
        while (!bus.ready && n < 400) begin
            tick();
            n++;
        end
        chk("pass_reaches_ready", 64'(bus.ready), 64'd1);
        if (exp_cycles > 0) chk("pass_cycles", 64'(n), 64'(exp_cycles));
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    endtask

    task automatic load_base();
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) w_mem[i][j] = 64'd0;
            x_mem[i] = 64'd0; b_mem[i] = 64'd0;
        end
        w_mem[0][0] = 64'd1; w_mem[0][1] = 64'd2; w_mem[0][2] = 64'd3;
        w_mem[1][0] = 64'd4; w_mem[1][1] = 64'd5; w_mem[1][2] = 64'd6;
        x_mem[0] = 64'd1; x_mem[1] = 64'd1; x_mem[2] = 64'd2;
        b_mem[0] = 64'd10; b_mem[1] = -64'sd1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, 64'(bus.ready), 64'd1);
        chk({tag, "_req"}, 64'(bus.operand_req), 64'd0);
        chk({tag, "_enable"}, 64'(bus.h_out_enable), 64'd0);
        chk({tag, "_h_out"}, bus.h_out, 64'd0);
        chk({tag, "_h_index"}, bus.h_out_l_index, 64'd0);
        chk({tag, "_l_index"}, bus.operand_l_index, 64'd0);
        chk({tag, "_x_index"}, bus.operand_x_index, 64'd0);
    endtask

    initial begin
        int n;
        bus.start = 0; bus.size_x_in = 0; bus.size_l_in = 0; bus.operand_valid = 0;
        bus.w_in = 0; bus.x_in = 0; bus.b_in = 0; bus.h_out_ready = 1;
        vpat = '{1'b1}; vptr = 0; hold_left = 0; cur_sx = 1; cur_sl = 1;
        clear_flags();
        load_base();

        #1;
        check_reset_outputs("reset");
        #20;
        rst_n = 1'b1;
        tick();

        // Back-to-back operands and results.
        run_pass(3, 2, 8);

        // Downstream holds off the first result for 5 cycles.
        hold_left = 5;
        run_pass(3, 2, 13);

        // Operand gaps.
        vpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        run_pass(3, 2, 0);
        vpat = '{1'b1};

        // Product overflow wraps, then a signed product.
        load_base();
        w_mem[0][0] = 64'h4000_0000_0000_0000; x_mem[0] = 64'd4; b_mem[0] = 64'd5;
        run_pass(1, 1, 2);
        w_mem[0][0] = -64'sd3; x_mem[0] = 64'd7; b_mem[0] = 64'd0;
        run_pass(1, 1, 2);
        load_base();

        // Zero-length input vector: start ignored.
        bus.size_x_in = 64'd0; bus.size_l_in = 64'd4; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("zero_size_ready", 64'(bus.ready), 64'd1);
            chk("zero_size_req", 64'(bus.operand_req), 64'd0);
            chk("zero_size_enable", 64'(bus.h_out_enable), 64'd0);
            tick();
        end

        // Reset in the middle of neuron 1's fetch, then a clean pass.
        start_pass(3, 2);
        n = 0;
        while (!(bus.operand_req && bus.operand_l_index == 64'd1) && n < 50) begin
            tick();
            n++;
        end
        chk("reached_l1_fetch", 64'(bus.operand_l_index), 64'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        sb.delete();
        clear_flags();
        tick();
        tick();
        check_reset_outputs("held_reset");
        rst_n = 1'b1;
        clear_flags();
        tick();
        run_pass(3, 2, 8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
